x_ramb_asym_dp_param: RTL and testbench
=======================================

// Module: x_ramb_asym_dp_param
// PURPOSE
//  Parametrised single-clock true dual-port block RAM with independently sized port widths.
//  It generalises the fixed 2/16-bit 4 Kbit primitive to any power-of-two width ratio.
//  Adds per-port write modes, an optional output pipeline register and a registered collision flag.
//  Sits in the simprims library as the memory model behind KCPSM3 program/scratch RAM wrappers.
// PARAMETERS
//  MEM_BITS      4096          total capacity in bits; power of two
//  WIDTH_A       2             port A data width; power of two, <= WIDTH_B
//  WIDTH_B       16            port B data width; power of two, <= 64, WIDTH_B % WIDTH_A == 0
//  WRITE_MODE_A  "WRITE_FIRST" port A write mode: "WRITE_FIRST" | "READ_FIRST" | "NO_CHANGE"
//  WRITE_MODE_B  "WRITE_FIRST" port B write mode, same options as WRITE_MODE_A
//  DO_REG        0             1 = extra output register on both ports (read latency 2)
//  INIT          0             MEM_BITS-wide initial contents; bit i = memory bit i
//  Derived: AW_A = log2(MEM_BITS/WIDTH_A); AW_B = log2(MEM_BITS/WIDTH_B); R = WIDTH_B/WIDTH_A
// PORTS
//  CLK        in   1        single clock for both ports; rising edge
//  RSTN       in   1        asynchronous reset, active low
//  ENA        in   1        port A enable; no read, write or RSTA effect when low
//  WEA        in   1        port A write enable (qualified by ENA)
//  RSTA       in   1        port A synchronous output reset (qualified by ENA)
//  ADDRA      in   AW_A     port A word address
//  DIA        in   WIDTH_A  port A write data
//  DOA        out  WIDTH_A  port A read data
//  ENB/WEB/RSTB/ADDRB/DIB/DOB  as port A, widths 1/1/1/AW_B/WIDTH_B/WIDTH_B
//  COLLISION  out  2        registered, one cycle: [0] write/write overlap; [1] read/write overlap
// BEHAVIOUR
//  Reset: RSTN low asynchronously clears DOA, DOB, both pipeline stages and COLLISION.
//   Memory contents are NOT cleared; they load INIT at time 0 only.
//  Bit map: A word j covers bits [j*WIDTH_A +: WIDTH_A]; B word k covers [k*WIDTH_B +: WIDTH_B].
//  Overlap: ENA & ENB & (ADDRA >> log2(R)) == ADDRB.
//  Latency: DO_REG=0 -> data at edge N available after edge N; DO_REG=1 -> after edge N+1.
//   The pipeline stage advances every cycle, independent of EN.
//  Enable: EN low holds the port's data output (first stage); memory is unchanged.
//  Write modes, same-port data on the write cycle:
//   WRITE_FIRST -> DO = new DI; READ_FIRST -> DO = prior contents; NO_CHANGE -> DO holds.
//  RSTx with ENx: first-stage DO <= 0 on the edge; a coincident write still commits.
//   With DO_REG=1, RSTx clears only the final stage.
//  Write/write overlap: both writes commit with B applied first, so A's slice holds DIA.
//   COLLISION[0] = 1 on the next cycle.
//  Read/write overlap (one port writes, other reads): the reader returns pre-write contents.
//   COLLISION[1] = 1 on the next cycle.
//  Both bits clear the following cycle unless the overlap repeats.
//  Non-overlapping simultaneous accesses are fully independent; no flag.
//  Address wrap: none needed; every address in range is valid.
//   X/Z bits on ADDR with EN high drive DO to all-X; no write occurs.
//  Elaboration: illegal width/ratio -> $display error and $finish.
// TESTING
//  1 Reset: RSTN=0 mid-read with DO_REG=1 -> DOA=0, DOB=0, COLLISION=0 at once;
//    INIT data reads back after release.
//  2 Width map: B writes ADDRB=3, DIB=16'hA5C3 -> A reads ADDRA 24..31 give 3,0,0,3,1,1,2,2
//    (LSB slice first).
//  3 Modes: READ_FIRST A on cell=2'b01, write 2'b10 -> DOA=2'b01 next cycle;
//    WRITE_FIRST -> 2'b10; NO_CHANGE -> DOA keeps previous value.
//  4 W/W collision: ADDRA=8, DIA=2'b11 with ADDRB=1, DIB=16'h0000 same edge
//    -> B readback 16'h0003; COLLISION=2'b01 for exactly one cycle.
//  5 R/W collision: A writes ADDRA=0, DIA=2'b10 over cell 2'b00 while B reads ADDRB=0
//    -> DOB[1:0]=2'b00, COLLISION=2'b10; next B read gives 2'b10.
//  6 RSTB with WEB=1, DIB=16'hFFFF -> DOB=0 that cycle; later read of the same address gives 16'hFFFF.

Source files
------------

// File: rtl/x_ramb_asym_dp_param.sv
// Single-clock true dual-port RAM with asymmetric power-of-two port widths,
// per-port write modes, optional output register and a registered collision flag.
module x_ramb_asym_dp_param #(
  parameter int                  MEM_BITS     = 4096,
  parameter int                  WIDTH_A      = 2,
  parameter int                  WIDTH_B      = 16,
  parameter string               WRITE_MODE_A = "WRITE_FIRST",
  parameter string               WRITE_MODE_B = "WRITE_FIRST",
  parameter bit                  DO_REG       = 1'b0,
  parameter logic [MEM_BITS-1:0] INIT         = '0,
  localparam int                 AW_A         = $clog2(MEM_BITS / WIDTH_A),
  localparam int                 AW_B         = $clog2(MEM_BITS / WIDTH_B)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               ena_i,
  input  logic               wea_i,
  input  logic               rsta_i,
  input  logic [AW_A-1:0]    addra_i,
  input  logic [WIDTH_A-1:0] dia_i,
  output logic [WIDTH_A-1:0] doa_o,
  input  logic               enb_i,
  input  logic               web_i,
  input  logic               rstb_i,
  input  logic [AW_B-1:0]    addrb_i,
  input  logic [WIDTH_B-1:0] dib_i,
  output logic [WIDTH_B-1:0] dob_o,
  output logic [1:0]         collision_o
);

  localparam int MW     = $clog2(MEM_BITS);
  localparam int LOG_WA = $clog2(WIDTH_A);
  localparam int LOG_WB = $clog2(WIDTH_B);
  localparam int LOG_R  = LOG_WB - LOG_WA;

  localparam bit A_WF = (WRITE_MODE_A == "WRITE_FIRST");
  localparam bit A_RF = (WRITE_MODE_A == "READ_FIRST");
  localparam bit A_NC = (WRITE_MODE_A == "NO_CHANGE");
  localparam bit B_WF = (WRITE_MODE_B == "WRITE_FIRST");
  localparam bit B_RF = (WRITE_MODE_B == "READ_FIRST");
  localparam bit B_NC = (WRITE_MODE_B == "NO_CHANGE");

  generate
    if (WIDTH_A < 1 || (WIDTH_A & (WIDTH_A - 1)) != 0 ||
        WIDTH_B < WIDTH_A || WIDTH_B > 64 || (WIDTH_B & (WIDTH_B - 1)) != 0 ||
        (MEM_BITS & (MEM_BITS - 1)) != 0 || MEM_BITS < 2 * WIDTH_B) begin : g_bad_width
      $fatal(1, "x_ramb_asym_dp_param: illegal MEM_BITS/WIDTH_A/WIDTH_B combination");
    end
    if (!(A_WF || A_RF || A_NC) || !(B_WF || B_RF || B_NC)) begin : g_bad_mode
      $fatal(1, "x_ramb_asym_dp_param: illegal WRITE_MODE_A/WRITE_MODE_B");
    end
  endgenerate

  // Contents are never reset; INIT is loaded once at time zero.
  logic [MEM_BITS-1:0] mem_q = INIT;

  logic [MW-1:0]      bit_a, bit_b;
  logic [WIDTH_A-1:0] rda;
  logic [WIDTH_B-1:0] rdb;
  logic               xa, xb, wra, wrb, ovl;

  assign bit_a = MW'(addra_i) << LOG_WA;
  assign bit_b = MW'(addrb_i) << LOG_WB;
  assign rda   = mem_q[bit_a +: WIDTH_A];
  assign rdb   = mem_q[bit_b +: WIDTH_B];
  assign xa    = $isunknown(addra_i);
  assign xb    = $isunknown(addrb_i);
  assign wra   = ena_i & wea_i & ~xa;
  assign wrb   = enb_i & web_i & ~xb;
  assign ovl   = ena_i & enb_i & (AW_B'(addra_i >> LOG_R) == addrb_i);

  // B is applied before A so that A's slice wins on a write/write overlap.
  always_ff @(posedge clk_i) begin
    if (wrb) mem_q[bit_b +: WIDTH_B] <= dib_i;
    if (wra) mem_q[bit_a +: WIDTH_A] <= dia_i;
  end

  logic [WIDTH_A-1:0] doa_p1_d, doa_p1_q;
  logic [WIDTH_B-1:0] dob_p1_d, dob_p1_q;
  logic [1:0]         collision_d, collision_q;

  assign collision_d = {ovl & (wea_i ^ web_i), ovl & wea_i & web_i};

  always_comb begin
    doa_p1_d = doa_p1_q;
    if (ena_i) begin
      if (rsta_i && !DO_REG) doa_p1_d = '0;
      else if (xa)           doa_p1_d = 'x;
      else if (!wea_i || A_RF) doa_p1_d = rda;
      else if (A_WF)         doa_p1_d = dia_i;
    end
  end

  always_comb begin
    dob_p1_d = dob_p1_q;
    if (enb_i) begin
      if (rstb_i && !DO_REG) dob_p1_d = '0;
      else if (xb)           dob_p1_d = 'x;
      else if (!web_i || B_RF) dob_p1_d = rdb;
      else if (B_WF)         dob_p1_d = dib_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      doa_p1_q    <= '0;
      dob_p1_q    <= '0;
      collision_q <= '0;
    end else begin
      doa_p1_q    <= doa_p1_d;
      dob_p1_q    <= dob_p1_d;
      collision_q <= collision_d;
    end
  end

  assign collision_o = collision_q;

  // Optional second stage: advances every cycle, RSTx clears only this stage.
  generate
    if (DO_REG) begin : g_do_reg
      logic [WIDTH_A-1:0] doa_p2_q;
      logic [WIDTH_B-1:0] dob_p2_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          doa_p2_q <= '0;
          dob_p2_q <= '0;
        end else begin
          doa_p2_q <= (ena_i && rsta_i) ? '0 : doa_p1_q;
          dob_p2_q <= (enb_i && rstb_i) ? '0 : dob_p1_q;
        end
      end
      assign doa_o = doa_p2_q;
      assign dob_o = dob_p2_q;
    end else begin : g_no_reg
      assign doa_o = doa_p1_q;
      assign dob_o = dob_p1_q;
    end
  endgenerate

endmodule

// File: tb/tb_x_ramb_asym_dp_param.sv
// Directed bench: four instances (write-first, read-first, no-change, registered)
// share one stimulus stream; expected values are hand-computed constants.
module tb_x_ramb_asym_dp_param;

  localparam logic [4095:0] INIT_V = 4096'h1234 << 1600;  // B word 100 = 16'h1234

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena, wea, rsta, enb, web, rstb;
  logic [10:0] addra;
  logic [1:0]  dia;
  logic [7:0]  addrb;
  logic [15:0] dib;

  logic [1:0]  doa_wf, doa_rf, doa_nc, doa_rg;
  logic [15:0] dob_wf, dob_rf, dob_nc, dob_rg;
  logic [1:0]  col_wf, col_rf, col_nc, col_rg;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  x_ramb_asym_dp_param #(.WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("WRITE_FIRST"),
                         .DO_REG(1'b0), .INIT(INIT_V)) u_wf (
    .clk_i(clk), .rst_ni(rst_n),
    .ena_i(ena), .wea_i(wea), .rsta_i(rsta), .addra_i(addra), .dia_i(dia), .doa_o(doa_wf),
    .enb_i(enb), .web_i(web), .rstb_i(rstb), .addrb_i(addrb), .dib_i(dib), .dob_o(dob_wf),
    .collision_o(col_wf));

  x_ramb_asym_dp_param #(.WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("READ_FIRST"),
                         .DO_REG(1'b0), .INIT(INIT_V)) u_rf (
    .clk_i(clk), .rst_ni(rst_n),
    .ena_i(ena), .wea_i(wea), .rsta_i(rsta), .addra_i(addra), .dia_i(dia), .doa_o(doa_rf),
    .enb_i(enb), .web_i(web), .rstb_i(rstb), .addrb_i(addrb), .dib_i(dib), .dob_o(dob_rf),
    .collision_o(col_rf));

  x_ramb_asym_dp_param #(.WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("NO_CHANGE"),
                         .DO_REG(1'b0), .INIT(INIT_V)) u_nc (
    .clk_i(clk), .rst_ni(rst_n),
    .ena_i(ena), .wea_i(wea), .rsta_i(rsta), .addra_i(addra), .dia_i(dia), .doa_o(doa_nc),
    .enb_i(enb), .web_i(web), .rstb_i(rstb), .addrb_i(addrb), .dib_i(dib), .dob_o(dob_nc),
    .collision_o(col_nc));

  x_ramb_asym_dp_param #(.WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("WRITE_FIRST"),
                         .DO_REG(1'b1), .INIT(INIT_V)) u_rg (
    .clk_i(clk), .rst_ni(rst_n),
    .ena_i(ena), .wea_i(wea), .rsta_i(rsta), .addra_i(addra), .dia_i(dia), .doa_o(doa_rg),
    .enb_i(enb), .web_i(web), .rstb_i(rstb), .addrb_i(addrb), .dib_i(dib), .dob_o(dob_rg),
    .collision_o(col_rg));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    ena = 1'b0; wea = 1'b0; rsta = 1'b0; addra = '0; dia = '0;
    enb = 1'b0; web = 1'b0; rstb = 1'b0; addrb = '0; dib = '0;
    step(); step();
    check("rst_doa_rg", doa_rg, 2'b00);
    check("rst_dob_rg", dob_rg, 16'h0000);
    check("rst_col_wf", col_wf, 2'b00);
    check("rst_dob_wf", dob_wf, 16'h0000);

    // INIT readback and registered latency
    rst_n = 1'b1;
    enb = 1'b1; addrb = 8'd100;
    ena = 1'b1; addra = 11'd801;
    step();
    check("init_dob_wf", dob_wf, 16'h1234);
    check("init_doa_wf", doa_wf, 2'b01);
    check("lat2_dob_rg_early", dob_rg, 16'h0000);
    step();
    check("lat2_dob_rg", dob_rg, 16'h1234);
    check("lat2_doa_rg", doa_rg, 2'b01);

    // asynchronous reset mid-read
    #2 rst_n = 1'b0;
    #1;
    check("async_dob_rg", dob_rg, 16'h0000);
    check("async_doa_rg", doa_rg, 2'b00);
    check("async_col_rg", col_rg, 2'b00);
    check("async_dob_wf", dob_wf, 16'h0000);
    #1 rst_n = 1'b1;
    step();
    check("rel_dob_wf", dob_wf, 16'h1234);
    check("rel_dob_rg_early", dob_rg, 16'h0000);
    step();
    check("rel_dob_rg", dob_rg, 16'h1234);

    // width map: B write word 3, A reads words 24..31
    ena = 1'b0;
    web = 1'b1; addrb = 8'd3; dib = 16'hA5C3;
    step();
    check("bmode_wf", dob_wf, 16'hA5C3);
    check("bmode_rf", dob_rf, 16'h0000);
    check("bmode_nc", dob_nc, 16'h1234);
    web = 1'b0; enb = 1'b0;
    ena = 1'b1;
    addra = 11'd24; step(); check("map24", doa_wf, 2'd3);
    addra = 11'd25; step(); check("map25", doa_wf, 2'd0);
    addra = 11'd26; step(); check("map26", doa_wf, 2'd0);
    addra = 11'd27; step(); check("map27", doa_wf, 2'd3);
    addra = 11'd28; step(); check("map28", doa_wf, 2'd1);
    addra = 11'd29; step(); check("map29", doa_wf, 2'd1);
    addra = 11'd30; step(); check("map30", doa_wf, 2'd2);
    addra = 11'd31; step(); check("map31", doa_wf, 2'd2);

    // port A write modes
    wea = 1'b1; addra = 11'd40; dia = 2'b01;
    step();
    check("amode1_wf", doa_wf, 2'b01);
    check("amode1_rf", doa_rf, 2'b00);
    check("amode1_nc", doa_nc, 2'b10);
    wea = 1'b0;
    step();
    check("amode_rd_nc", doa_nc, 2'b01);
    wea = 1'b1; dia = 2'b10;
    step();
    check("amode2_wf", doa_wf, 2'b10);
    check("amode2_rf", doa_rf, 2'b01);
    check("amode2_nc", doa_nc, 2'b01);
    wea = 1'b0;
    step();
    check("amode_rd2_nc", doa_nc, 2'b10);

    // write/write overlap
    ena = 1'b1; wea = 1'b1; addra = 11'd8; dia = 2'b11;
    enb = 1'b1; web = 1'b1; addrb = 8'd1; dib = 16'h0000;
    step();
    check("ww_col", col_wf, 2'b01);
    ena = 1'b0; wea = 1'b0; web = 1'b0;
    step();
    check("ww_readback", dob_wf, 16'h0003);
    check("ww_col_clear", col_wf, 2'b00);

    // read/write overlap
    ena = 1'b1; wea = 1'b1; addra = 11'd0; dia = 2'b10;
    enb = 1'b1; web = 1'b0; addrb = 8'd0;
    step();
    check("rw_old_data", dob_wf[1:0], 2'b00);
    check("rw_col", col_wf, 2'b10);
    ena = 1'b0; wea = 1'b0;
    step();
    check("rw_readback", dob_wf, 16'h0002);
    check("rw_col_clear", col_wf, 2'b00);

    // RSTB with coincident write
    enb = 1'b1; web = 1'b1; rstb = 1'b1; addrb = 8'd7; dib = 16'hFFFF;
    step();
    check("rstb_wf", dob_wf, 16'h0000);
    check("rstb_rf", dob_rf, 16'h0000);
    check("rstb_rg", dob_rg, 16'h0000);
    web = 1'b0; rstb = 1'b0;
    step();
    check("rstb_commit_wf", dob_wf, 16'hFFFF);
    check("rstb_stage1_rg", dob_rg, 16'hFFFF);

    // enable low holds output
    enb = 1'b0; addrb = 8'd100;
    step();
    check("en_hold", dob_wf, 16'hFFFF);

    // independent non-overlapping accesses
    ena = 1'b1; wea = 1'b1; addra = 11'd900; dia = 2'b11;
    enb = 1'b1; addrb = 8'd3;
    step();
    check("indep_dob", dob_wf, 16'hA5C3);
    check("indep_doa", doa_wf, 2'b11);
    check("indep_col", col_wf, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
